// File: rtl/majority_pkg.sv
// Shared helpers for the majority stream voter:
// default spatial threshold and word popcount.
package majority_pkg;

  function automatic int maj_thresh(input int width);
    return width / 2 + 1;
  endfunction

  // Zero-extend narrower words to 64 bits before calling.
  function automatic logic [6:0] popcount(input logic [63:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) begin
      c = c + 7'(d[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/majority_window.sv
// Sliding window of the last WIN spatial votes.
// Ports: clk, rst_n, clear, load, vote in; count, fill out.
module majority_window
  import majority_pkg::*;
#(
  parameter int WIN = 5,
  parameter int WCW = $clog2(WIN + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           load,
  input  logic           vote,
  output logic [WCW-1:0] count,
  output logic [WCW-1:0] fill
);

  logic [WIN-1:0] bits;
  logic [WIN-1:0] bits_n;
  logic [WCW-1:0] count_n;
  logic [WCW-1:0] fill_n;
  logic           full;
  logic           evict;

  assign full  = (fill == WCW'(WIN));
  // The oldest bit only leaves the count once the window is full.
  assign evict = bits[WIN-1] & full;

  always_comb begin
    bits_n  = bits;
    count_n = count;
    fill_n  = fill;
    if (clear) begin
      // A vote loaded during clear becomes the first entry.
      bits_n  = load ? WIN'(vote) : '0;
      count_n = load ? WCW'(vote) : '0;
      fill_n  = load ? WCW'(1) : '0;
    end else if (load) begin
      bits_n[0] = vote;
      for (int i = 1; i < WIN; i++) begin
        bits_n[i] = bits[i-1];
      end
      count_n = count + WCW'(vote) - WCW'(evict);
      fill_n  = full ? fill : fill + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bits  <= '0;
      count <= '0;
      fill  <= '0;
    end else begin
      bits  <= bits_n;
      count <= count_n;
      fill  <= fill_n;
    end
  end

endmodule

// File: rtl/majority_stream_voter.sv
// Two-stage streaming majority voter: popcount, spatial
// vote vs threshold, and temporal vote over WIN results.
// Ports: clk, rst_n, clear, thresh; in_valid/in_ready/
// in_data; out_valid/out_ready/out_cnt/out_bit/out_win/
// out_wfull.
module majority_stream_voter
  import majority_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WIN   = 5,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int WCW   = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] thresh,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_bit,
  output logic             out_win,
  output logic             out_wfull
);

  logic             adv;
  logic             s1_valid;
  logic [CNT_W-1:0] s1_cnt;
  logic [CNT_W-1:0] s1_thr;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] eff_thr;
  logic             vote;
  logic             win_load;
  logic [WCW-1:0]   w_count;
  logic [WCW-1:0]   w_fill;

  assign adv      = !out_valid | out_ready;
  // S1 may fill a bubble even while S2 is stalled.
  assign in_ready = adv | !s1_valid;

  assign word_cnt = CNT_W'(popcount(64'(in_data)));
  assign eff_thr  = (thresh == '0)
                  ? CNT_W'(maj_thresh(WIDTH))
                  : thresh;

  // Threshold above WIDTH can never be met: no wrap.
  assign vote     = (s1_cnt >= s1_thr);
  assign win_load = adv & s1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_thr   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cnt <= word_cnt;
        s1_thr <= eff_thr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_bit   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_cnt <= s1_cnt;
        out_bit <= vote;
      end
    end
  end

  majority_window #(
    .WIN (WIN),
    .WCW (WCW)
  ) u_window (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .load  (win_load),
    .vote  (vote),
    .count (w_count),
    .fill  (w_fill)
  );

  // Window registers update with S2, so these
  // reflect the post-update count of the held result.
  assign out_win   = (w_count >= WCW'(WIN / 2 + 1));
  assign out_wfull = (w_fill == WCW'(WIN));

endmodule

// File: tb/tb_majority_stream_voter.sv
// Directed bench for majority_stream_voter
// (WIDTH=8, WIN=5).
module tb_majority_stream_voter;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [3:0] thresh;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_cnt;
  logic       out_bit;
  logic       out_win;
  logic       out_wfull;

  int checks;
  int errors;

  majority_stream_voter #(
    .WIDTH (8),
    .WIN   (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .thresh    (thresh),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cnt   (out_cnt),
    .out_bit   (out_bit),
    .out_win   (out_win),
    .out_wfull (out_wfull)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] thr;
    logic [3:0] cnt;
    logic       b;
    logic       win;
    logic       wfull;
  } vec_t;

  localparam int N = 14;
  vec_t tv[N];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word alone and wait until it is on the output.
  task automatic send1(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    thresh   = 4'd0;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  logic [7:0] ws[4];
  logic [3:0] rx[2];
  logic [3:0] snap;
  logic       hit;
  int         acc;
  int         got;

  initial begin
    checks = 0;
    errors = 0;
    tv[0]  = '{8'd15,  4'd0, 4'd4, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{8'd25,  4'd0, 4'd3, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{8'd95,  4'd0, 4'd6, 1'b1, 1'b0, 1'b0};
    tv[3]  = '{8'd5,   4'd0, 4'd2, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{8'd3,   4'd0, 4'd2, 1'b0, 1'b0, 1'b1};
    tv[5]  = '{8'd255, 4'd0, 4'd8, 1'b1, 1'b0, 1'b1};
    tv[6]  = '{8'd255, 4'd0, 4'd8, 1'b1, 1'b1, 1'b1};
    tv[7]  = '{8'd3,   4'd2, 4'd2, 1'b1, 1'b1, 1'b1};
    tv[8]  = '{8'd255, 4'd9, 4'd8, 1'b0, 1'b1, 1'b1};
    tv[9]  = '{8'h00,  4'd0, 4'd0, 1'b0, 1'b1, 1'b1};
    tv[10] = '{8'h00,  4'd0, 4'd0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{8'hF0,  4'd4, 4'd4, 1'b1, 1'b0, 1'b1};
    tv[12] = '{8'h1F,  4'd0, 4'd5, 1'b1, 1'b0, 1'b1};
    tv[13] = '{8'h80,  4'd1, 4'd1, 1'b1, 1'b1, 1'b1};
    ws[0] = 8'h01;
    ws[1] = 8'h03;
    ws[2] = 8'h07;
    ws[3] = 8'h0F;

    rst_n     = 1'b0;
    clear     = 1'b0;
    thresh    = 4'd0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_cnt",   32'(out_cnt),   0);
    chk("rst_out_bit",   32'(out_bit),   0);
    chk("rst_out_wfull", 32'(out_wfull), 0);
    chk("rst_out_win",   32'(out_win),   0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  32'(in_ready),  1);

    // Back-to-back stream, one word per cycle.
    for (int i = 0; i <= N; i++) begin
      if (i < N) begin
        in_valid = 1'b1;
        in_data  = tv[i].data;
        thresh   = tv[i].thr;
        chk($sformatf("tv%0d_in_ready", i),
            32'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i == 0) begin
        chk("lat_first_not_yet", 32'(out_valid), 0);
      end else begin
        chk($sformatf("tv%0d_valid", i-1),
            32'(out_valid), 1);
        chk($sformatf("tv%0d_cnt", i-1),
            32'(out_cnt), 32'(tv[i-1].cnt));
        chk($sformatf("tv%0d_bit", i-1),
            32'(out_bit), 32'(tv[i-1].b));
        chk($sformatf("tv%0d_win", i-1),
            32'(out_win), 32'(tv[i-1].win));
        chk($sformatf("tv%0d_wfull", i-1),
            32'(out_wfull), 32'(tv[i-1].wfull));
      end
    end
    tick();
    chk("drain_valid", 32'(out_valid), 0);

    // Downstream stall with continuous input.
    out_ready = 1'b0;
    thresh    = 4'd0;
    acc       = 0;
    snap      = 4'd0;
    #1;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_data  = ws[acc];
      hit      = in_ready;
      @(posedge clk);
      if (hit) acc++;
      #1;
      if (c == 2) snap = out_cnt;
      if (c == 3) chk("stall_cnt_stable",
                      32'(out_cnt), 32'(snap));
    end
    chk("stall_accepts",   32'(acc),       2);
    chk("stall_ready_low", 32'(in_ready),  0);
    chk("stall_valid",     32'(out_valid), 1);
    chk("stall_head_cnt",  32'(out_cnt),   1);

    in_valid  = 1'b0;
    out_ready = 1'b1;
    got       = 0;
    rx[0]     = 4'hF;
    rx[1]     = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (out_valid) begin
        if (got < 2) rx[got] = out_cnt;
        got++;
      end
      tick();
    end
    chk("release_count", 32'(got),   2);
    chk("release_cnt0",  32'(rx[0]), 1);
    chk("release_cnt1",  32'(rx[1]), 2);

    // Clear coinciding with an S2 load on a full window.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    thresh   = 4'd0;
    tick();
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    chk("clr_load_valid", 32'(out_valid), 1);
    chk("clr_load_bit",   32'(out_bit),   1);
    chk("clr_load_wfull", 32'(out_wfull), 0);
    chk("clr_load_win",   32'(out_win),   0);
    for (int k = 1; k <= 4; k++) begin
      send1(8'hFF);
      chk($sformatf("refill%0d_wfull", k),
          32'(out_wfull), 32'(k == 4));
      chk($sformatf("refill%0d_win", k),
          32'(out_win), 32'(k >= 2));
    end

    // Clear alone, no load.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_only_wfull", 32'(out_wfull), 0);
    chk("clr_only_win",   32'(out_win),   0);

    // Reset mid-stream with words in flight.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tick();
    tick();
    chk("pre_rst_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_wfull", 32'(out_wfull), 0);
    chk("mid_rst_cnt",   32'(out_cnt),   0);
    chk("mid_rst_ready", 32'(in_ready),  1);
    rst_n = 1'b1;
    got   = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (out_valid) got++;
    end
    chk("post_rst_no_output", 32'(got), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
